cpu_mem_responder: RTL and testbench

Services CPU memory cycles after the address decoder has classified them. ROM requests are served from a one-line (4-word) read buffer that refills from SDRAM over a toggle handshake. Work RAM requests (0xa0000-0xaffff) are served from an internal 32K x 16 block RAM. The block returns read data and a one-cycle `cpu_ready` completion pulse to the CPU bus interface.

---
 rtl/cpu_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: completes decoded CPU memory cycles.
// ROM reads are served from a single 4-word line buffer that refills from
// SDRAM over a toggle handshake; work RAM lives in an internal 32K x 16
// block RAM with byte writes. Every cycle ends with a one-cycle cpu_ready_o.
module cpu_mem_responder #(
   parameter logic [24:0] ROM_BASE = 25'h0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cpu_req_i,
   input  logic        cpu_rd_i,
   input  logic        cpu_wr_i,
   input  logic [1:0]  cpu_be_i,
   input  logic [19:0] cpu_addr_i,
   input  logic [15:0] cpu_dout_i,
   input  logic [19:0] rom_addr_i,
   input  logic        cpu_rom_memrq_i,
   input  logic        cpu_ram_memrq_i,
   input  logic        flush_i,
   output logic [15:0] cpu_din_o,
   output logic        cpu_ready_o,
   output logic [24:0] sdr_addr_o,
   output logic        sdr_req_o,
   input  logic        sdr_ack_i,
   input  logic [63:0] sdr_data_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RAM_RD = 2'd1,
      FETCH  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      state_q;
   logic        valid_q;
   logic [16:0] tag_q;
   logic [1:0]  sel_q;
   logic [63:0] line_q;
   logic [15:0] din_q;
   logic        ready_q;
   logic        sdr_req_q;
   logic [24:0] sdr_addr_q;

   // Work RAM split into byte lanes so each byte enable writes independently.
   logic [7:0]  ram_hi_q [0:32767];
   logic [7:0]  ram_lo_q [0:32767];
   logic [15:0] ram_rdata_q;

   logic [16:0] rom_tag_s;
   logic        hit_s;
   logic [14:0] ram_idx_s;
   logic        ram_wr_s;
   logic        unused_s;

   // Pick 16-bit word n (bits [16n+15:16n]) out of a 64-bit line.
   function automatic logic [15:0] word_of(input logic [63:0] line, input logic [1:0] sel);
      logic [15:0] w;
      case (sel)
         2'd0:    w = line[15:0];
         2'd1:    w = line[31:16];
         2'd2:    w = line[47:32];
         2'd3:    w = line[63:48];
         default: w = 16'hFFFF;
      endcase
      return w;
   endfunction

   assign rom_tag_s = rom_addr_i[19:3];
   // Hit uses the registered valid bit, so a same-cycle flush cannot cancel it.
   assign hit_s     = valid_q && (tag_q == rom_tag_s);
   assign ram_idx_s = cpu_addr_i[15:1];
   assign ram_wr_s  = (state_q == IDLE) && cpu_req_i && cpu_ram_memrq_i && cpu_wr_i;
   // Address bits outside the RAM window and byte offsets are not needed here.
   assign unused_s  = ^{cpu_addr_i[19:16], cpu_addr_i[0], rom_addr_i[0]};

   // Block RAM: byte-lane writes and a registered read of the requested word.
   always_ff @(posedge clk_i) begin
      if (ram_wr_s && cpu_be_i[0]) begin
         ram_lo_q[ram_idx_s] <= cpu_dout_i[7:0];
      end
      if (ram_wr_s && cpu_be_i[1]) begin
         ram_hi_q[ram_idx_s] <= cpu_dout_i[15:8];
      end
      ram_rdata_q <= {ram_hi_q[ram_idx_s], ram_lo_q[ram_idx_s]};
   end

   // Request FSM: classifies the cycle, runs the line fill, issues completion.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         tag_q      <= 17'h0;
         sel_q      <= 2'd0;
         line_q     <= 64'h0;
         din_q      <= 16'hFFFF;
         ready_q    <= 1'b0;
         sdr_req_q  <= 1'b0;
         sdr_addr_q <= 25'h0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu_req_i) begin
                  if (cpu_ram_memrq_i && cpu_wr_i) begin
                     din_q   <= 16'hFFFF;
                     state_q <= DONE;
                  end else if (cpu_ram_memrq_i && cpu_rd_i) begin
                     state_q <= RAM_RD;
                  end else if (cpu_rom_memrq_i && cpu_rd_i && hit_s) begin
                     din_q   <= word_of(line_q, rom_addr_i[2:1]);
                     state_q <= DONE;
                  end else if (cpu_rom_memrq_i && cpu_rd_i) begin
                     sdr_addr_q <= ROM_BASE + {5'b00000, rom_tag_s, 3'b000};
                     sdr_req_q  <= ~sdr_req_q;
                     tag_q      <= rom_tag_s;
                     sel_q      <= rom_addr_i[2:1];
                     state_q    <= FETCH;
                  end else begin
                     // ROM writes and unmapped cycles complete with open-bus data.
                     din_q   <= 16'hFFFF;
                     state_q <= DONE;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RAM_RD: begin
               din_q   <= ram_rdata_q;
               state_q <= DONE;
            end
            FETCH: begin
               if (sdr_ack_i == sdr_req_q) begin
                  line_q  <= sdr_data_i;
                  valid_q <= 1'b1;
                  din_q   <= word_of(sdr_data_i, sel_q);
                  state_q <= DONE;
               end else begin
                  state_q <= FETCH;
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // Flush overrides any valid set by a fill completing this cycle.
         if (flush_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign cpu_din_o   = din_q;
   assign cpu_ready_o = ready_q;
   assign sdr_addr_o  = sdr_addr_q;
   assign sdr_req_o   = sdr_req_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed, table-driven bench for cpu_mem_responder.
module tb_cpu_mem_responder;

   localparam logic [24:0] RB = 25'h100_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_rd, cpu_wr;
   logic [1:0]  cpu_be;
   logic [19:0] cpu_addr, rom_addr;
   logic [15:0] cpu_dout;
   logic        rom_mrq, ram_mrq, flush;
   logic [15:0] cpu_din;
   logic        cpu_ready;
   logic [24:0] sdr_addr;
   logic        sdr_req, sdr_ack;
   logic [63:0] sdr_data;

   int checks = 0;
   int errors = 0;
   logic exp_req = 1'b0;

   cpu_mem_responder #(.ROM_BASE(RB)) dut (
      .clk_i(clk), .reset_i(reset), .cpu_req_i(cpu_req), .cpu_rd_i(cpu_rd),
      .cpu_wr_i(cpu_wr), .cpu_be_i(cpu_be), .cpu_addr_i(cpu_addr),
      .cpu_dout_i(cpu_dout), .rom_addr_i(rom_addr), .cpu_rom_memrq_i(rom_mrq),
      .cpu_ram_memrq_i(ram_mrq), .flush_i(flush), .cpu_din_o(cpu_din),
      .cpu_ready_o(cpu_ready), .sdr_addr_o(sdr_addr), .sdr_req_o(sdr_req),
      .sdr_ack_i(sdr_ack), .sdr_data_i(sdr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rom, ram, rd, wr;
      logic [19:0] addr, raddr;
      logic [1:0]  be;
      logic [15:0] wdata;
      logic        flush_req;
      logic        fetch;
      int          ack_dly;
      logic        flush_ack;
      logic [63:0] line;
      logic [24:0] exp_addr;
      logic [15:0] exp_din;
      int          exp_lat;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic rom, ram, rd, wr, input logic [19:0] addr, raddr,
                               input logic [1:0] be, input logic [15:0] wdata, input logic flush_req,
                               input logic fetch, input int ack_dly, input logic flush_ack,
                               input logic [63:0] line, input logic [24:0] exp_addr,
                               input logic [15:0] exp_din, input int exp_lat);
      vec_t v;
      v.rom = rom; v.ram = ram; v.rd = rd; v.wr = wr; v.addr = addr; v.raddr = raddr;
      v.be = be; v.wdata = wdata; v.flush_req = flush_req; v.fetch = fetch;
      v.ack_dly = ack_dly; v.flush_ack = flush_ack; v.line = line;
      v.exp_addr = exp_addr; v.exp_din = exp_din; v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   edges;
      logic seen;
      @(posedge clk); #1;
      cpu_rd = v.rd; cpu_wr = v.wr; rom_mrq = v.rom; ram_mrq = v.ram;
      cpu_addr = v.addr; rom_addr = v.raddr; cpu_be = v.be; cpu_dout = v.wdata;
      cpu_req = 1'b1; flush = v.flush_req;
      @(posedge clk); #1;
      cpu_req = 1'b0; flush = 1'b0; edges = 1;
      if (v.fetch) begin
         exp_req = ~exp_req;
         check("sdr_req_toggle", idx, 64'(sdr_req), 64'(exp_req));
         check("sdr_addr", idx, 64'(sdr_addr), 64'(v.exp_addr));
         for (int d = 0; d < v.ack_dly; d++) begin
            check("ready_before_ack", idx, 64'(cpu_ready), 64'd0);
            @(posedge clk); #1; edges++;
         end
         sdr_data = v.line; sdr_ack = exp_req; flush = v.flush_ack;
         @(posedge clk); #1;
         flush = 1'b0; edges++;
      end
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (cpu_ready) seen = 1'b1;
         else begin
            @(posedge clk); #1; edges++;
         end
      end
      check("ready_seen", idx, 64'(seen), 64'd1);
      if (!v.fetch) begin
         check("latency", idx, 64'(edges), 64'(v.exp_lat));
         check("no_sdr_activity", idx, 64'(sdr_req), 64'(exp_req));
      end
      check("din", idx, 64'(cpu_din), 64'(v.exp_din));
      @(posedge clk); #1;
      check("ready_one_cycle", idx, 64'(cpu_ready), 64'd0);
   endtask

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_be = 2'b00;
      cpu_addr = 20'h0; rom_addr = 20'h0; cpu_dout = 16'h0; rom_mrq = 1'b0;
      ram_mrq = 1'b0; flush = 1'b0; sdr_ack = 1'b0; sdr_data = 64'h0;

      //          rom   ram   rd    wr    addr        raddr       be     wdata     flreq fetch dly flack line                     exp_addr       din       lat
      vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h00010, 20'h00010, 2'b11, 16'h0000, 1'b0, 1'b1, 2, 1'b0, 64'h4444_3333_2222_1111, RB + 25'h10,  16'h1111, 0);
      vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h00016, 20'h00016, 2'b11, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'h4444, 2);
      vecs[2]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h00012, 20'h00012, 2'b11, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'h2222, 2);
      vecs[3]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h00012, 20'h00012, 2'b11, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 64'h8888_7777_6666_5555, RB + 25'h10,  16'h6666, 0);
      vecs[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h00014, 20'h00014, 2'b11, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 64'hDDDD_CCCC_BBBB_AAAA, RB + 25'h10,  16'hCCCC, 0);
      vecs[5]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h0001E, 20'h0001E, 2'b11, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 64'h0123_4567_89AB_CDEF, RB + 25'h18,  16'h0123, 0);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 20'hA0100, 20'h00000, 2'b11, 16'h1234, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'hFFFF, 2);
      vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 20'hA0100, 20'h00000, 2'b01, 16'hBEEF, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'hFFFF, 2);
      vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 20'hA0100, 20'h00000, 2'b11, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'h12EF, 3);
      vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 20'h0001C, 20'h0001C, 2'b11, 16'h5A5A, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'hFFFF, 2);
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 20'h40000, 20'h00000, 2'b11, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'hFFFF, 2);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 20'hA0100, 20'h00000, 2'b11, 16'h7777, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'hFFFF, 2);
      vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 20'hA0100, 20'h00000, 2'b11, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'h12EF, 3);
      vecs[13] = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h0001C, 20'h0001C, 2'b11, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'h4567, 2);
      vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b1, 20'hA0102, 20'h00000, 2'b11, 16'hAAAA, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'hFFFF, 2);
      vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b1, 20'hA0102, 20'h00000, 2'b10, 16'h5678, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'hFFFF, 2);
      vecs[16] = mk(1'b0, 1'b1, 1'b1, 1'b0, 20'hA0102, 20'h00000, 2'b11, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 64'h0,                 25'h0,         16'h56AA, 3);

      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", -1, 64'(cpu_ready), 64'd0);
      check("reset_din", -1, 64'(cpu_din), 64'hFFFF);
      check("reset_sdr_req", -1, 64'(sdr_req), 64'd0);
      check("reset_sdr_addr", -1, 64'(sdr_addr), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset in the middle of a line fill: the fill is dropped silently.
      @(posedge clk); #1;
      cpu_rd = 1'b1; cpu_wr = 1'b0; rom_mrq = 1'b1; ram_mrq = 1'b0;
      rom_addr = 20'h00100; cpu_addr = 20'h00100; cpu_req = 1'b1;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      exp_req = ~exp_req;
      check("abort_sdr_req_toggle", 100, 64'(sdr_req), 64'(exp_req));
      check("abort_sdr_addr", 100, 64'(sdr_addr), 64'(RB + 25'h100));
      @(posedge clk); #1;
      reset = 1'b1; sdr_ack = 1'b0; exp_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_reset_sdr_req", 101, 64'(sdr_req), 64'd0);
      check("abort_reset_din", 101, 64'(cpu_din), 64'hFFFF);
      check("abort_reset_sdr_addr", 101, 64'(sdr_addr), 64'd0);
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         check("abort_no_ready", 102 + j, 64'(cpu_ready), 64'd0);
         @(posedge clk); #1;
      end
      run_vec(110, mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h00100, 20'h00100, 2'b11, 16'h0000, 1'b0, 1'b1, 1, 1'b0,
                      64'hF00D_CAFE_BEEF_9ABC, RB + 25'h100, 16'h9ABC, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
